// File: rtl/tinychip_pkg.sv
// rtl/tinychip_pkg.sv - shared TinyChip fetch-path widths, halt encoding and imem FSM states
package tinychip_pkg;

  localparam int IMEM_IW = 9;
  localparam int IMEM_AW = 8;
  localparam logic [IMEM_IW-1:0] IMEM_HALT_WORD = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x IW instruction storage with per-entry valid bits and bulk clear
module imem_array #(
  parameter int IW = 9,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o,
  output logic          rvalid_o
);

  localparam int DEPTH = 2 ** AW;

  logic [IW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A bulk clear and the first word of a new program land on the same edge.
  always_comb begin
    valid_d = clr_i ? '0 : valid_q;
    if (we_i) begin
      valid_d[waddr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rvalid_o = valid_q[raddr_i];
  assign rdata_o  = rvalid_o ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - loadable instruction memory with registered, stallable fetch port
module imem_fetch_unit
  import tinychip_pkg::*;
#(
  parameter int             IW        = IMEM_IW,
  parameter int             AW        = IMEM_AW,
  parameter bit             HALT_EN   = 1'b1,
  parameter logic [IW-1:0]  HALT_WORD = '1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  input  logic          fetch_ready,
  output logic          instr_valid,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_addr,
  output logic          done,
  output logic          err_unld,
  output logic [1:0]    state_o
);

  localparam logic [AW:0] LEN_ONE = 1;

  imem_state_e   state_q;
  logic [AW:0]   prog_len_q;
  logic [AW:0]   prog_len_d;
  logic          instr_valid_q;
  logic [IW-1:0] instr_q;
  logic [AW-1:0] instr_addr_q;
  logic          done_q;
  logic          err_unld_q;

  logic          load_acc;
  logic          load_fresh;
  logic          stall;
  logic          accept;
  logic          beyond;
  logic          miss;
  logic          halt_hit;
  logic          deliver;
  logic          end_ev;
  logic [IW-1:0] rdata;
  logic          rvalid;

  imem_array #(.IW(IW), .AW(AW)) u_array (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (load_fresh),
    .we_i     (load_acc),
    .waddr_i  (load_addr),
    .wdata_i  (load_data),
    .raddr_i  (fetch_addr),
    .rdata_o  (rdata),
    .rvalid_o (rvalid)
  );

  assign load_acc   = load_en & (state_q != RUN);
  assign load_fresh = load_en & ((state_q == EMPTY) | (state_q == DONE));
  assign prog_len_d = (load_acc & load_last) ? ({1'b0, load_addr} + LEN_ONE) : prog_len_q;

  assign stall    = instr_valid_q & ~fetch_ready;
  assign accept   = fetch_req & (state_q == RUN) & ~stall;
  assign beyond   = {1'b0, fetch_addr} >= prog_len_q;
  assign miss     = beyond | ~rvalid;
  assign halt_hit = HALT_EN & (rdata == HALT_WORD);
  assign deliver  = accept & ~miss;
  assign end_ev   = accept & (miss | halt_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= EMPTY;
      prog_len_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_addr_q  <= '0;
      done_q        <= 1'b0;
      err_unld_q    <= 1'b0;
    end else begin
      prog_len_q <= prog_len_d;
      case (state_q)
        EMPTY, LOAD, DONE: if (load_en) state_q <= load_last ? RUN : LOAD;
        RUN:               if (end_ev) state_q <= DONE;
        default:           state_q <= EMPTY;
      endcase
      if (load_fresh) begin
        done_q     <= 1'b0;
        err_unld_q <= 1'b0;
      end else if (end_ev) begin
        done_q <= 1'b1;
        if (~beyond & ~rvalid) err_unld_q <= 1'b1;
      end
      // A held word stays put while stalled; it retires on fetch_ready unless replaced.
      if (deliver) begin
        instr_valid_q <= 1'b1;
        instr_q       <= rdata;
        instr_addr_q  <= fetch_addr;
      end else if (~stall) begin
        instr_valid_q <= 1'b0;
      end
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_addr  = instr_addr_q;
  assign done        = done_q;
  assign err_unld    = err_unld_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - randomized self-checking bench for imem_fetch_unit
module tb_imem_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en;
  logic [7:0] load_addr;
  logic [8:0] load_data;
  logic       load_last;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_ready;
  logic       instr_valid;
  logic [8:0] instr;
  logic [7:0] instr_addr;
  logic       done;
  logic       err_unld;
  logic [1:0] state_o;

  imem_fetch_unit #(.IW(9), .AW(8), .HALT_EN(1'b1), .HALT_WORD(9'h1FF)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_last   (load_last),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_addr  (instr_addr),
    .done        (done),
    .err_unld    (err_unld),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Program-level reference: contents, loaded flags, length, phase and expected output word.
  logic [8:0] m_mem   [256];
  bit         m_valid [256];
  int         m_len;
  logic [1:0] m_state;
  bit         m_done;
  bit         m_err;
  bit         exp_valid;
  logic [8:0] exp_instr;
  logic [7:0] exp_addr;

  logic [21:0] act_v;
  logic [21:0] exp_v;

  function automatic logic [8:0] rand_word();
    return 9'($urandom_range(0, 510));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 0;
    m_len = 0; m_state = 2'd0; m_done = 0; m_err = 0;
    exp_valid = 0; exp_instr = '0; exp_addr = '0;
  endtask

  task automatic snap();
    act_v = {instr_valid, instr, instr_addr, done, err_unld, state_o};
    exp_v = {exp_valid, exp_instr, exp_addr, m_done, m_err, m_state};
  endtask

  task automatic load_word(input int a, input logic [8:0] d, input bit last);
    load_en = 1; load_addr = 8'(a); load_data = d; load_last = last; fetch_req = 0;
    step();
    load_en = 0; load_last = 0;
    exp_valid = 0;
    if (m_state != 2'd2) begin
      if (m_state == 2'd0 || m_state == 2'd3) begin
        for (int i = 0; i < 256; i++) m_valid[i] = 0;
        m_done = 0; m_err = 0;
      end
      m_mem[a] = d; m_valid[a] = 1;
      if (last) begin m_len = a + 1; m_state = 2'd2; end
      else m_state = 2'd1;
    end
  endtask

  task automatic fetch(input int a);
    fetch_req = 1; fetch_addr = 8'(a);
    step();
    fetch_req = 0;
    if (m_state == 2'd2) begin
      if (a >= m_len || !m_valid[a]) begin
        exp_valid = 0; m_done = 1; m_state = 2'd3;
        if (a < m_len) m_err = 1;
      end else begin
        exp_valid = 1; exp_instr = m_mem[a]; exp_addr = 8'(a);
        if (m_mem[a] == 9'h1FF) begin m_done = 1; m_state = 2'd3; end
      end
    end else begin
      exp_valid = 0;
    end
  endtask

  task automatic apply_reset();
    reset = 1;
    step();
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({instr_valid, instr, instr_addr, done, err_unld, state_o} !== 22'h0) begin
      bad++; $display("FAIL reset_state: got %h want 0", {instr_valid, instr, instr_addr, done, err_unld, state_o});
    end
  endtask

  task automatic test_basic();
    for (int a = 0; a < 5; a++) load_word(a, rand_word(), a == 4);
    snap(); total++;
    if (act_v !== exp_v) begin bad++; $display("FAIL basic_loaded: got %h want %h", act_v, exp_v); end
    for (int a = 0; a <= 5; a++) begin
      fetch(a);
      snap(); total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL basic_fetch%0d: got %h want %h", a, act_v, exp_v); end
    end
  endtask

  task automatic test_stall();
    for (int a = 0; a < 5; a++) load_word(a, rand_word(), a == 4);
    for (int a = 0; a < 3; a++) fetch(a);
    fetch_ready = 0; fetch_req = 1; fetch_addr = 8'd3;
    for (int c = 0; c < 3; c++) begin
      step();
      snap(); total++;
      if (act_v !== {1'b1, m_mem[2], 8'd2, 1'b0, 1'b0, 2'd2}) begin
        bad++; $display("FAIL stall_hold%0d: got %h want %h", c, act_v, {1'b1, m_mem[2], 8'd2, 4'b0010});
      end
    end
    fetch_ready = 1;
    for (int a = 3; a < 5; a++) begin
      fetch(a);
      snap(); total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL stall_resume%0d: got %h want %h", a, act_v, exp_v); end
    end
  endtask

  task automatic test_unloaded();
    load_word(0, rand_word(), 0);
    fetch(0);
    snap(); total++;
    if (act_v !== exp_v) begin bad++; $display("FAIL fetch_in_load: got %h want %h", act_v, exp_v); end
    load_word(1, rand_word(), 0);
    load_word(3, rand_word(), 1);
    fetch(0);
    fetch(2);
    snap(); total++;
    if (act_v !== exp_v) begin bad++; $display("FAIL unloaded_end: got %h want %h", act_v, exp_v); end
  endtask

  task automatic test_halt();
    load_word(0, rand_word(), 0);
    load_word(1, 9'h1FF, 0);
    load_word(2, rand_word(), 1);
    for (int a = 0; a < 3; a++) begin
      fetch(a);
      snap(); total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL halt_fetch%0d: got %h want %h", a, act_v, exp_v); end
    end
  endtask

  task automatic test_run_load_ignored();
    for (int a = 0; a < 4; a++) load_word(a, rand_word(), a == 3);
    load_word(1, rand_word(), 1);
    fetch(1);
    snap(); total++;
    if (act_v !== exp_v) begin bad++; $display("FAIL run_load_ignored: got %h want %h", act_v, exp_v); end
    fetch(3);
    snap(); total++;
    if (act_v !== exp_v) begin bad++; $display("FAIL run_len_kept: got %h want %h", act_v, exp_v); end
  endtask

  task automatic test_full_depth();
    fetch(200);
    load_word(255, rand_word(), 1);
    fetch(255);
    snap(); total++;
    if (act_v !== exp_v) begin bad++; $display("FAIL depth_last: got %h want %h", act_v, exp_v); end
    fetch(254);
    snap(); total++;
    if (act_v !== exp_v) begin bad++; $display("FAIL depth_unloaded: got %h want %h", act_v, exp_v); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n;
      int order[$];
      n = $urandom_range(2, 12);
      for (int i = 0; i < n - 1; i++) if ($urandom_range(0, 3) != 0) order.push_back(i);
      for (int i = order.size() - 1; i > 0; i--) begin
        int j;
        int t;
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      foreach (order[k]) load_word(order[k], ($urandom_range(0, 7) == 0) ? 9'h1FF : rand_word(), 0);
      load_word(n - 1, rand_word(), 1);
      for (int f = 0; f < 8; f++) begin
        fetch($urandom_range(0, n + 1));
        snap(); total++;
        if (act_v !== exp_v) begin bad++; $display("FAIL random_r%0d_f%0d: got %h want %h", r, f, act_v, exp_v); end
      end
      fetch(255);
    end
  endtask

  task automatic test_reset_mid();
    load_word(0, rand_word(), 0);
    load_en = 1; load_addr = 8'd1; load_data = rand_word(); load_last = 0;
    #2 reset = 1;
    #1;
    total++;
    if ({instr_valid, instr, instr_addr, done, err_unld, state_o} !== 22'h0) begin
      bad++; $display("FAIL reset_mid_load: got %h want 0", {instr_valid, instr, instr_addr, done, err_unld, state_o});
    end
    load_en = 0;
    step();
    #2 reset = 0;
    model_reset();
    for (int a = 0; a < 3; a++) load_word(a, rand_word(), a == 2);
    fetch(1);
    fetch_ready = 0;
    step();
    #2 reset = 1;
    #1;
    total++;
    if ({instr_valid, instr, instr_addr, done, err_unld, state_o} !== 22'h0) begin
      bad++; $display("FAIL reset_mid_stall: got %h want 0", {instr_valid, instr, instr_addr, done, err_unld, state_o});
    end
    step();
    #2 reset = 0;
    fetch_ready = 1;
    model_reset();
    for (int a = 0; a < 4; a++) load_word(a, rand_word(), a == 3);
    for (int a = 0; a <= 4; a++) begin
      fetch(a);
      snap(); total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL reload_fetch%0d: got %h want %h", a, act_v, exp_v); end
    end
  endtask

  initial begin
    reset = 1; load_en = 0; load_addr = '0; load_data = '0; load_last = 0;
    fetch_req = 0; fetch_addr = '0; fetch_ready = 1;
    test_reset();
    test_basic();
    test_stall();
    test_unloaded();
    test_halt();
    test_run_load_ignored();
    test_full_depth();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
